// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage with one outstanding IF request and a 1-entry skid buffer.
// Build option IFETCH_IRQ_EN: an external IRQ with MSR.EE set is delivered as a fault=1 entry.
module ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0100,
  parameter logic [31:0] RESET_MSR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRQ,
  input  logic [31:0] wb_newpc,
  input  logic [31:0] wb_newmsr,
  input  logic        wb_newpcmsr_valid,
  input  logic        exe_annul,
  input  logic        wb_annul,
  input  logic [31:0] mem_newpc,
  input  logic [31:0] mem_newmsr,
  input  logic        mem_newpc_valid,
  input  logic        mem_newmsr_valid,
  input  logic        decode_stall,
  output logic        ifetch_valid,
  output logic [3:0]  ifetch_fault,
  output logic [31:0] ifetch_pc,
  output logic [31:0] ifetch_msr,
  output logic [31:0] ifetch_instr,
  output logic [31:0] emi_if_address,
  output logic        emi_if_req,
  input  logic [63:0] emi_if_rdata,
  input  logic        emi_if_valid
);

  // state  | meaning
  // S_IDLE | no request outstanding; may issue a fetch or take an IRQ
  // S_WAIT | request outstanding; its response will be delivered
  // S_DROP | request outstanding; its response is discarded on return
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_msr;
  logic [31:3] addr_q;
  logic        halted;

  logic        buf_valid;
  logic [3:0]  buf_fault;
  logic [31:0] buf_pc;
  logic [31:0] buf_msr;
  logic [31:0] buf_instr;

  logic        redirect;
  logic        annul;
  logic        flush;
  logic        slot_free;
  logic        resp;
  logic        resp_take;
  logic        irq_take;
  logic        can_start;
  logic        issue;
  logic        new_entry;
  logic [31:0] next_pc;
  logic [31:0] resp_instr;
  logic [31:0] new_instr;
  logic [3:0]  new_fault;
  logic [31:3] issue_dw;

  assign redirect   = wb_newpcmsr_valid | mem_newpc_valid;
  assign annul      = exe_annul | wb_annul;
  assign flush      = redirect | annul;
  assign slot_free  = !ifetch_valid || !decode_stall;
  assign resp       = (state == S_WAIT) && emi_if_valid;
  assign resp_take  = resp && !flush;
  assign next_pc    = fetch_pc + 32'd4;
  assign resp_instr = fetch_pc[2] ? emi_if_rdata[63:32] : emi_if_rdata[31:0];
  assign can_start  = !reset && !flush && !halted && !buf_valid;

`ifdef IFETCH_IRQ_EN
  assign irq_take = can_start && (state == S_IDLE) && IRQ && fetch_msr[15];
`else
  logic irq_unused;
  assign irq_unused = IRQ;
  assign irq_take   = 1'b0;
`endif

  // A response may immediately chain the next request when it goes straight to the output.
  assign issue     = can_start && (((state == S_IDLE) && !irq_take) || (resp && slot_free));
  assign issue_dw  = (state == S_WAIT) ? next_pc[31:3] : fetch_pc[31:3];
  assign new_entry = resp_take || irq_take;
  assign new_instr = irq_take ? 32'd0 : resp_instr;
  assign new_fault = irq_take ? 4'd1 : 4'd0;

  assign emi_if_req     = issue;
  assign emi_if_address = {(issue ? issue_dw : addr_q), 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_PC;
      fetch_msr    <= RESET_MSR;
      addr_q       <= '0;
      halted       <= 1'b0;
      buf_valid    <= 1'b0;
      buf_fault    <= 4'd0;
      buf_pc       <= 32'd0;
      buf_msr      <= 32'd0;
      buf_instr    <= 32'd0;
      ifetch_valid <= 1'b0;
      ifetch_fault <= 4'd0;
      ifetch_pc    <= RESET_PC;
      ifetch_msr   <= RESET_MSR;
      ifetch_instr <= 32'd0;
    end else begin
      case (state)
        S_IDLE:  if (issue) state <= S_WAIT;
        S_WAIT: begin
          if (resp)       state <= issue ? S_WAIT : S_IDLE;
          else if (flush) state <= S_DROP;
        end
        S_DROP:  if (emi_if_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (issue) addr_q <= issue_dw;

      if (wb_newpcmsr_valid) begin
        fetch_pc  <= wb_newpc;
        fetch_msr <= wb_newmsr;
      end else begin
        if (mem_newpc_valid) fetch_pc <= mem_newpc;
        else if (resp_take)  fetch_pc <= next_pc;
        if (mem_newmsr_valid) fetch_msr <= mem_newmsr;
      end

      if (redirect)                halted <= 1'b0;
      else if (annul || irq_take)  halted <= 1'b1;

      // Output slot first, skid buffer only when decode holds the slot.
      if (flush) begin
        ifetch_valid <= 1'b0;
        buf_valid    <= 1'b0;
      end else if (slot_free) begin
        if (buf_valid) begin
          ifetch_valid <= 1'b1;
          ifetch_fault <= buf_fault;
          ifetch_pc    <= buf_pc;
          ifetch_msr   <= buf_msr;
          ifetch_instr <= buf_instr;
          buf_valid    <= 1'b0;
        end else if (new_entry) begin
          ifetch_valid <= 1'b1;
          ifetch_fault <= new_fault;
          ifetch_pc    <= fetch_pc;
          ifetch_msr   <= fetch_msr;
          ifetch_instr <= new_instr;
        end else begin
          ifetch_valid <= 1'b0;
        end
      end else if (new_entry) begin
        buf_valid <= 1'b1;
        buf_fault <= new_fault;
        buf_pc    <= fetch_pc;
        buf_msr   <= fetch_msr;
        buf_instr <= new_instr;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized scoreboard bench for ifetch with a magic-pattern IF memory
// and an LFSR-driven decode stall.
module tb_ifetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRQ;
  logic [31:0] wb_newpc, wb_newmsr;
  logic        wb_newpcmsr_valid;
  logic        exe_annul, wb_annul;
  logic [31:0] mem_newpc, mem_newmsr;
  logic        mem_newpc_valid, mem_newmsr_valid;
  logic        decode_stall;
  logic        ifetch_valid;
  logic [3:0]  ifetch_fault;
  logic [31:0] ifetch_pc, ifetch_msr, ifetch_instr;
  logic [31:0] emi_if_address;
  logic        emi_if_req;
  logic [63:0] emi_if_rdata;
  logic        emi_if_valid;

  ifetch #(.RESET_PC(RESET_PC), .RESET_MSR(32'h0)) dut (
    .clk(clk), .reset(reset), .IRQ(IRQ),
    .wb_newpc(wb_newpc), .wb_newmsr(wb_newmsr), .wb_newpcmsr_valid(wb_newpcmsr_valid),
    .exe_annul(exe_annul), .wb_annul(wb_annul),
    .mem_newpc(mem_newpc), .mem_newmsr(mem_newmsr),
    .mem_newpc_valid(mem_newpc_valid), .mem_newmsr_valid(mem_newmsr_valid),
    .decode_stall(decode_stall),
    .ifetch_valid(ifetch_valid), .ifetch_fault(ifetch_fault), .ifetch_pc(ifetch_pc),
    .ifetch_msr(ifetch_msr), .ifetch_instr(ifetch_instr),
    .emi_if_address(emi_if_address), .emi_if_req(emi_if_req),
    .emi_if_rdata(emi_if_rdata), .emi_if_valid(emi_if_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] magic(input logic [9:0] n);
    logic [31:0] a, b, c;
    a = {2'b00, n, n, n};
    b = {4'h0, n[8:0], n[8:0], n[8:0], 1'b0};
    c = {16'h0, n[3:0], n[3:0], n[3:0], 4'h1};
    return a ^ b ^ c;
  endfunction

  function automatic logic [63:0] dword(input logic [31:0] a);
    logic [9:0] lo, hi;
    lo = {a[11:3], 1'b0};
    hi = {a[11:3], 1'b1};
    return {magic(hi), magic(lo)};
  endfunction

  // Memory: synchronous read on req, optional extra random latency.
  bit          lat_en = 1'b0;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          lat_r;
  int          req_total = 0;

  always @(posedge clk) begin
    if (emi_if_req && !reset) req_total <= req_total + 1;
    if (reset) begin
      emi_if_valid <= 1'b0;
      pend         <= 1'b0;
    end else begin
      emi_if_valid <= 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          emi_if_rdata <= dword(pend_addr);
          emi_if_valid <= 1'b1;
          pend         <= 1'b0;
        end else begin
          pend_wait <= pend_wait - 1;
        end
      end
      if (emi_if_req) begin
        lat_r = lat_en ? int'($urandom_range(0, 2)) : 0;
        if (lat_r == 0) begin
          emi_if_rdata <= dword(emi_if_address);
          emi_if_valid <= 1'b1;
        end else begin
          pend      <= 1'b1;
          pend_addr <= emi_if_address;
          pend_wait <= lat_r - 1;
        end
      end
    end
  end

  // Decode model: stall when LFSR bits 3 and 9 are both set.
  logic [15:0] rng;
  logic [15:0] rng_seed;
  bit          stall_en = 1'b0;
  always @(posedge clk) begin
    if (reset) rng <= rng_seed;
    else       rng <= {rng[14:0], rng[15] ^ rng[13] ^ rng[12] ^ rng[10]};
  end
  assign decode_stall = stall_en & rng[3] & rng[9];

  // Reference stream: the instructions decode should see, in order.
  typedef struct packed {
    logic [3:0]  fault;
    logic [31:0] pc;
    logic [31:0] msr;
    logic [31:0] instr;
  } ent_t;

  ent_t exp_q[$];
  bit   model_live = 1'b0;

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] msr);
    ent_t e;
    e.fault = 4'd0;
    e.pc    = pc;
    e.msr   = msr;
    e.instr = magic(pc[11:2]);
    return e;
  endfunction

  task automatic model_restart(input logic [31:0] pc, input logic [31:0] msr, input bit live);
    exp_q.delete();
    model_live = live;
    if (live) for (int k = 0; k < 8; k++) exp_q.push_back(mk(pc + 32'(4 * k), msr));
  endtask

  // Monitor: pops on every accepted output, checks hold-while-stalled.
  ent_t         e_pop, e_last;
  bit           hold_prev = 1'b0;
  logic [100:0] prev_out;

  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold", 128'({ifetch_valid, ifetch_fault, ifetch_pc, ifetch_msr, ifetch_instr}),
              128'(prev_out));
      if (ifetch_valid && !decode_stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected: got pc %h fault %0d, expected no instruction", ifetch_pc, ifetch_fault);
        end else begin
          e_pop = exp_q.pop_front();
          n_acc++;
          check("scoreboard", 128'({ifetch_fault, ifetch_pc, ifetch_msr, ifetch_instr}), 128'(e_pop));
          if (model_live && exp_q.size() > 0) begin
            e_last = exp_q[$];
            exp_q.push_back(mk(e_last.pc + 32'd4, e_last.msr));
          end
        end
      end
      hold_prev = ifetch_valid && decode_stall && !wb_newpcmsr_valid && !mem_newpc_valid
                  && !exe_annul && !wb_annul;
      prev_out  = {ifetch_valid, ifetch_fault, ifetch_pc, ifetch_msr, ifetch_instr};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] cur_msr;

  task automatic redirect_wb(input logic [31:0] pc, input logic [31:0] msr, input bit live);
    wb_newpc = pc;
    wb_newmsr = msr;
    wb_newpcmsr_valid = 1'b1;
    cyc(1);
    wb_newpcmsr_valid = 1'b0;
    cur_msr = msr;
    model_restart(pc, msr, live);
  endtask

  task automatic redirect_mem(input logic [31:0] pc);
    mem_newpc = pc;
    mem_newpc_valid = 1'b1;
    cyc(1);
    mem_newpc_valid = 1'b0;
    model_restart(pc, cur_msr, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int first_valid;
  int n_valid;
  int r0;
  int acc0;
  int found;

  initial begin
    reset = 1'b1;
    IRQ = 1'b0;
    wb_newpc = '0; wb_newmsr = '0; wb_newpcmsr_valid = 1'b0;
    exe_annul = 1'b0; wb_annul = 1'b0;
    mem_newpc = '0; mem_newmsr = '0; mem_newpc_valid = 1'b0; mem_newmsr_valid = 1'b0;
    rng_seed = 16'($urandom_range(1, 65535));
    cur_msr = 32'h0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 128'(ifetch_valid), 128'(0));
    check("rst_fault", 128'(ifetch_fault), 128'(0));
    check("rst_instr", 128'(ifetch_instr), 128'(0));
    check("rst_pc",    128'(ifetch_pc),    128'(32'h100));
    check("rst_msr",   128'(ifetch_msr),   128'(0));
    check("rst_req",   128'(emi_if_req),   128'(0));

    @(posedge clk);
    #1 reset = 1'b0;
    model_restart(RESET_PC, 32'h0, 1'b1);

    // Streaming startup: first valid two cycles after release, then one per cycle.
    first_valid = -1;
    n_valid = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifetch_valid && first_valid < 0) first_valid = k;
      if (ifetch_valid) n_valid++;
    end
    check("first_valid_cycle", 128'(first_valid), 128'(2));
    check("stream_rate", 128'(n_valid), 128'(10));

    // Random stall and memory latency.
    cyc(1);
    stall_en = 1'b1;
    lat_en = 1'b1;
    acc0 = n_acc;
    cyc(200);
    check("stall_progress", 128'(n_acc > acc0), 128'(1));

    redirect_mem(32'h40);
    cyc(30);

    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (ifetch_valid && decode_stall) found = 1;
      else cyc(1);
    end
    check("stall_seen", 128'(found), 128'(1));
    redirect_wb(32'h200, 32'h8000, 1'b1);
    cyc(30);

    for (int i = 0; i < 8; i++) begin
      cyc(int'($urandom_range(5, 30)));
      if ($urandom_range(0, 1) == 1)
        redirect_wb(32'($urandom_range(0, 2047)) << 2, $urandom & 32'hFFFF_7FFF, 1'b1);
      else
        redirect_mem(32'($urandom_range(0, 2047)) << 2);
    end
    cyc(30);

    // Annul halts fetching; MSR-only update does not restart it.
    exe_annul = 1'b1;
    r0 = req_total;
    cyc(1);
    exe_annul = 1'b0;
    model_restart(32'h0, cur_msr, 1'b0);
    cyc(15);
    mem_newmsr = 32'h1234;
    mem_newmsr_valid = 1'b1;
    cyc(1);
    mem_newmsr_valid = 1'b0;
    cur_msr = 32'h1234;
    cyc(5);
    check("annul_no_req", 128'(req_total - r0), 128'(0));
    check("annul_valid", 128'(ifetch_valid), 128'(0));
    redirect_mem(32'h300);
    cyc(30);

    // Annul with a same-cycle redirect: the redirect still applies.
    wb_annul = 1'b1;
    mem_newpc = 32'h500;
    mem_newpc_valid = 1'b1;
    cyc(1);
    wb_annul = 1'b0;
    mem_newpc_valid = 1'b0;
    model_restart(32'h500, cur_msr, 1'b1);
    cyc(30);

    redirect_wb(32'hFFFF_FFF0, cur_msr, 1'b1);
    cyc(40);

`ifdef IFETCH_IRQ_EN
    IRQ = 1'b1;
    redirect_wb(32'h600, 32'h8000, 1'b0);
    exp_q.push_back('{fault: 4'd1, pc: 32'h600, msr: 32'h8000, instr: 32'h0});
    r0 = req_total;
    cyc(60);
    check("irq_no_fetch", 128'(req_total - r0), 128'(0));
    check("irq_delivered", 128'(exp_q.size()), 128'(0));
    IRQ = 1'b0;
    redirect_wb(32'h700, 32'h0, 1'b1);
    cyc(30);
`else
    IRQ = 1'b1;
    redirect_wb(32'h600, 32'h8000, 1'b1);
    acc0 = n_acc;
    cyc(40);
    check("irq_ignored_progress", 128'(n_acc > acc0), 128'(1));
    IRQ = 1'b0;
`endif

    stall_en = 1'b0;
    acc0 = n_acc;
    cyc(10);
    check("final_progress", 128'(n_acc > acc0), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
